// File: rtl/sync_ram_bist.sv
// March C- built-in self-test initiator for a single-port synchronous RAM.
// Drives the RAM port while busy and checks one-cycle-latency read data.
module sync_ram_bist #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ELEM_W = 3;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [ELEM_W-1:0]     ELEM_END = ELEM_W'(6);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_n;

  // Pointer to the next access to present: element, op slot, address
  logic [ELEM_W-1:0]     elem, elem_n;
  logic                  op, op_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;

  // Read currently on the RAM port and its expected word
  logic                  rd, rd_n;
  logic [DATA_WIDTH-1:0] rd_exp, rd_exp_n;

  // Compare stage: read sampled by the RAM at the previous edge
  logic                  cmp_valid, cmp_valid_n;
  logic [DATA_WIDTH-1:0] cmp_exp, cmp_exp_n;
  logic [ADDR_WIDTH-1:0] cmp_addr, cmp_addr_n;

  logic                  busy_n, done_n, pass_n;
  logic [CNT_W-1:0]      fail_count_n;
  logic [ADDR_WIDTH-1:0] fail_addr_n;
  logic                  ram_we_n;
  logic [ADDR_WIDTH-1:0] ram_addr_n;
  logic [DATA_WIDTH-1:0] ram_din_n;

  logic e_down, e_pair, op_read, op_val, op_last, addr_last, next_down;
  logic issue, mismatch;

  // March C- element decode for the pointed-to access
  always_comb begin
    e_down    = (elem == ELEM_W'(3)) || (elem == ELEM_W'(4));
    e_pair    = (elem >= ELEM_W'(1)) && (elem <= ELEM_W'(4));
    op_read   = (elem == ELEM_W'(5)) || (e_pair && !op);
    op_val    = e_pair && (((elem == ELEM_W'(2)) || (elem == ELEM_W'(4))) ^ op);
    op_last   = !e_pair || op;
    addr_last = e_down ? (addr == '0) : (addr == ADDR_TOP);
    next_down = (elem == ELEM_W'(2)) || (elem == ELEM_W'(3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (elem == ELEM_END) state_n = S_DRAIN;
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign issue    = ((state == S_IDLE) && start) || ((state == S_RUN) && (elem != ELEM_END));
  assign mismatch = cmp_valid && (ram_dout != cmp_exp);

  always_comb begin
    elem_n       = elem;
    op_n         = op;
    addr_n       = addr;
    rd_n         = 1'b0;
    rd_exp_n     = '0;
    cmp_valid_n  = rd;
    cmp_exp_n    = rd_exp;
    cmp_addr_n   = ram_addr;
    busy_n       = (state_n != S_IDLE);
    done_n       = (state == S_DRAIN);
    pass_n       = pass;
    fail_count_n = fail_count;
    fail_addr_n  = fail_addr;
    ram_we_n     = 1'b0;
    ram_addr_n   = '0;
    ram_din_n    = '0;

    if (mismatch) begin
      if (fail_count != CNT_MAX) fail_count_n = fail_count + CNT_W'(1);
      if (fail_count == '0)      fail_addr_n  = cmp_addr;
    end

    if (state == S_DRAIN) pass_n = (fail_count_n == '0);

    if ((state == S_IDLE) && start) begin
      fail_count_n = '0;
      fail_addr_n  = '0;
      pass_n       = 1'b0;
    end

    if (issue) begin
      ram_we_n   = !op_read;
      ram_addr_n = addr;
      ram_din_n  = op_read ? '0 : {DATA_WIDTH{op_val}};
      rd_n       = op_read;
      rd_exp_n   = {DATA_WIDTH{op_val}};
      // All ops at one address complete before the address moves on
      if (!op_last) begin
        op_n = 1'b1;
      end else begin
        op_n = 1'b0;
        if (addr_last) begin
          elem_n = elem + ELEM_W'(1);
          addr_n = next_down ? ADDR_TOP : '0;
        end else begin
          addr_n = e_down ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
        end
      end
    end else if (state == S_DRAIN) begin
      elem_n = '0;
      op_n   = 1'b0;
      addr_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem       <= '0;
      op         <= 1'b0;
      addr       <= '0;
      rd         <= 1'b0;
      rd_exp     <= '0;
      cmp_valid  <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      elem       <= elem_n;
      op         <= op_n;
      addr       <= addr_n;
      rd         <= rd_n;
      rd_exp     <= rd_exp_n;
      cmp_valid  <= cmp_valid_n;
      cmp_exp    <= cmp_exp_n;
      cmp_addr   <= cmp_addr_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      fail_count <= fail_count_n;
      fail_addr  <= fail_addr_n;
      ram_we     <= ram_we_n;
      ram_addr   <= ram_addr_n;
      ram_din    <= ram_din_n;
    end
  end

endmodule

// File: tb/tb_sync_ram_bist.sv
// Bench for sync_ram_bist: behavioural RAM with injectable stuck-at faults,
// March C- reference model, directed scenarios plus random fault runs.
module tb_sync_ram_bist;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned N   = 1 << AW;
  localparam int unsigned ACC = 10 * N;
  localparam int unsigned AWB = 6;
  localparam int unsigned NB  = 1 << AWB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_b;
  logic busy, done, pass, ram_we;
  logic [7:0] fail_count;
  logic [AW-1:0] fail_addr, ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic busy_b, done_b, pass_b, ram_we_b;
  logic [7:0] fail_count_b;
  logic [AWB-1:0] fail_addr_b, ram_addr_b;
  logic [DW-1:0] ram_din_b, ram_dout_b;

  sync_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_addr(fail_addr), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  sync_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fail_count_b), .fail_addr(fail_addr_b), .ram_we(ram_we_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b));

  // Stuck-at fault applied to the stored cell
  bit f_en, f_all, f_val;
  int unsigned f_addr, f_bit;

  function automatic logic [DW-1:0] stuck(input logic [DW-1:0] d, input int unsigned a);
    logic [DW-1:0] r;
    r = d;
    if (f_en && (f_all || a == f_addr)) r[f_bit] = f_val;
    return r;
  endfunction

  // Read-first synchronous RAMs
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= stuck(ram_din, int'(ram_addr));
    ram_dout <= mem[ram_addr];
  end

  // Large RAM: bit 0 stuck-at-1 and bit 7 stuck-at-0 everywhere, so every read fails
  logic [DW-1:0] mem_b [NB];
  always @(posedge clk) begin
    if (ram_we_b) mem_b[ram_addr_b] <= (ram_din_b | 8'h01) & 8'h7F;
    ram_dout_b <= mem_b[ram_addr_b];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: expected access list and outcome of one March C- run
  string elem_ops [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  bit    elem_down[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int m_we [ACC];
  int m_addr [ACC];
  int m_din [ACC];
  int m_fc, m_fa, m_pass;

  function automatic void build_model();
    logic [DW-1:0] mm [N];
    logic [DW-1:0] word;
    string s;
    int idx, a, mis;
    bit seen;
    idx = 0; mis = 0; seen = 0; m_fa = 0;
    for (int i = 0; i < int'(N); i++) mm[i] = '0;
    for (int e = 0; e < 6; e++) begin
      s = elem_ops[e];
      for (int st = 0; st < int'(N); st++) begin
        a = elem_down[e] ? int'(N) - 1 - st : st;
        for (int k = 0; k < s.len(); k += 2) begin
          word = (s[k+1] == "1") ? {DW{1'b1}} : {DW{1'b0}};
          m_addr[idx] = a;
          if (s[k] == "w") begin
            m_we[idx] = 1; m_din[idx] = int'(word);
            mm[a] = stuck(word, a);
          end else begin
            m_we[idx] = 0; m_din[idx] = 0;
            if (mm[a] != word) begin
              mis++;
              if (!seen) begin seen = 1; m_fa = a; end
            end
          end
          idx++;
        end
      end
    end
    m_fc   = (mis > 255) ? 255 : mis;
    m_pass = (mis == 0) ? 1 : 0;
  endfunction

  task automatic run_test(input string tag, input int pulse_at, input int rst_at, input bit hold);
    int seq_bad, busy_bad, done_cnt, first_done, second_done, last;
    seq_bad = 0; busy_bad = 0; done_cnt = 0; first_done = -1; second_done = -1;
    last = hold ? 2 * int'(ACC) + 4 : int'(ACC) + 2;
    build_model();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) start = 1'b0;
      if (hold && c == int'(ACC) + 2) start = 1'b0;
      if (c == pulse_at) start = 1'b1;
      if (pulse_at >= 0 && c == pulse_at + 1) start = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "/rst_we"}, int'(ram_we), 0);
        check({tag, "/rst_busy"}, int'(busy), 0);
        check({tag, "/rst_fc"}, int'(fail_count), 0);
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          if (done || ram_we || busy) busy_bad++;
        end
        check({tag, "/rst_quiet"}, busy_bad, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "/rst_no_done"}, int'(done), 0);
        return;
      end
      if (c == 0) begin
        check({tag, "/fc_cleared"}, int'(fail_count), 0);
        check({tag, "/pass_cleared"}, int'(pass), 0);
      end
      if (c < int'(ACC)) begin
        if (int'(ram_we) != m_we[c] || int'(ram_addr) != m_addr[c] || int'(ram_din) != m_din[c])
          seq_bad++;
      end
      if (c <= int'(ACC) && !busy) busy_bad++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (hold && c == int'(ACC) + 2) check({tag, "/restart_busy"}, int'(busy), 1);
      if (c == int'(ACC) + 1 || (hold && c == 2 * int'(ACC) + 3)) begin
        check({tag, "/idle_busy"}, int'(busy), 0);
        check({tag, "/pass"}, int'(pass), m_pass);
        check({tag, "/fail_count"}, int'(fail_count), m_fc);
        check({tag, "/fail_addr"}, int'(fail_addr), m_fa);
      end
    end
    check({tag, "/seq"}, seq_bad, 0);
    check({tag, "/busy_run"}, busy_bad, 0);
    check({tag, "/done_at"}, first_done, int'(ACC) + 1);
    check({tag, "/done_count"}, done_cnt, hold ? 2 : 1);
    if (hold) check({tag, "/done2_at"}, second_done, 2 * int'(ACC) + 3);
  endtask

  initial begin
    int bd;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    f_en = 0; f_all = 0; f_val = 0; f_addr = 0; f_bit = 0;
    repeat (3) @(negedge clk);
    check("reset/busy", int'(busy), 0);
    check("reset/done", int'(done), 0);
    check("reset/pass", int'(pass), 0);
    check("reset/fail_count", int'(fail_count), 0);
    check("reset/fail_addr", int'(fail_addr), 0);
    check("reset/ram_we", int'(ram_we), 0);
    check("reset/ram_addr", int'(ram_addr), 0);
    check("reset/ram_din", int'(ram_din), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_test("clean", -1, -1, 1'b0);
    f_en = 1; f_all = 0; f_addr = 5; f_bit = 3; f_val = 0;
    run_test("sa0_a5_b3", -1, -1, 1'b0);
    f_all = 1; f_bit = 0; f_val = 1;
    run_test("sa1_b0_all", -1, -1, 1'b0);
    f_en = 0;
    run_test("clean_after_fault", -1, -1, 1'b0);
    run_test("start_while_busy", 40, -1, 1'b0);
    run_test("reset_mid", -1, 70, 1'b0);
    run_test("after_reset", -1, -1, 1'b0);
    run_test("start_held", -1, -1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      f_en   = 1;
      f_all  = ($urandom_range(0, 3) == 0);
      f_addr = $urandom_range(0, N - 1);
      f_bit  = $urandom_range(0, DW - 1);
      f_val  = 1'($urandom_range(0, 1));
      run_test($sformatf("rand%0d", t), -1, -1, 1'b0);
    end
    f_en = 0;

    // Every one of 5*NB reads mismatches: count must saturate
    bd = -1;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 10 * int'(NB) + 5; c++) begin
      @(negedge clk);
      if (c == 0) start_b = 1'b0;
      if (done_b && bd < 0) bd = c;
    end
    check("big/done_at", bd, 10 * int'(NB) + 1);
    check("big/fail_count", int'(fail_count_b), (5 * int'(NB) > 255) ? 255 : 5 * int'(NB));
    check("big/fail_addr", int'(fail_addr_b), 0);
    check("big/pass", int'(pass_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ram_bist.md
# sync_ram_bist

Built-in self-test initiator for the single-port synchronous RAM: drives `we/addr/din` and checks `dout` (one-cycle read latency, read-first on same-address write). On `start` it runs March C- over every address, counts mismatches and reports pass/fail. It sits between the RAM and the system's test/control logic, muxed onto the RAM port while `busy`.

## Interface
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width; depth N = 2**ADDR_WIDTH.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a test run; sampled only in IDLE.
- `busy` output 1: test in progress.
- `done` output 1: one-cycle pulse at end of run.
- `pass` output 1: last run had zero mismatches; held until the next accepted `start`.
- `fail_count` output 8: mismatching reads in the current/last run; saturates at 255.
- `fail_addr` output ADDR_WIDTH: address of the first mismatch; 0 if none.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_WIDTH: RAM address.
- `ram_din` output DATA_WIDTH: RAM write data.
- `ram_dout` input DATA_WIDTH: RAM read data, valid the cycle after the read is sampled.

## Operation
- States: IDLE -> RUN (accepted `start`) -> DRAIN (after the last access is issued) -> IDLE (`done` pulses on this transition).
- Reset: state IDLE; `busy`, `done`, `pass`, `ram_we` = 0; `fail_count`, `fail_addr`, `ram_addr`, `ram_din` = 0; compare pipeline cleared.
- March C- elements, in order; 0 = all-zeros word, 1 = all-ones word:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Address ordering: up runs 0..N-1, down runs N-1..0. Address counter reloads at each element boundary with no idle cycle.
- Access count: one access per cycle. Within an element, all ops at one address complete before the address advances. Total 10N accesses.
- Reads: `ram_we` = 0, `ram_din` = 0.
- Compare pipeline: a read sampled by the RAM at edge t registers (valid, expected, addr). `ram_dout` is compared to expected at edge t+1. An r-then-w at the same address is legal because the RAM returns old data.
- On mismatch: `fail_count` increments, saturating at 255. `fail_addr` is captured only when `fail_count` was 0. The test always runs to completion.
- Accepted `start`: clears `fail_count`, `fail_addr` and `pass`.
- `start` while `busy` is ignored. `start` held high after `done` begins a new run on the next IDLE cycle.
- In IDLE: `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.

## Timing
- `start` sampled high in IDLE at edge k:
  - `busy` = 1 after edge k.
  - Access i (0..10N-1) is presented after edge k+i and sampled by the RAM at edge k+1+i.
- Last access (M5 read at N-1) is sampled at edge k+10N; state -> DRAIN.
- Its compare completes at edge k+10N+1. After that edge:
  - `busy` = 0
  - `done` = 1 for exactly one cycle
  - `pass` = (`fail_count` == 0)
- N=16: 160 accesses; `done` high in the cycle after edge k+161.
- RAM outputs are registered; no combinational path from `ram_dout` or `start` to the `ram_*` outputs.
- Asynchronous reset mid-run:
  - `ram_we` drops immediately, with no further writes.
  - All outputs take their reset values.
  - `done` is not pulsed.

## Test plan
- **Fault-free model RAM, N=16, start at edge k** -> first accesses are w@0..w@15 with `ram_din` = 00, then r@0, w@0 (FF); `done` after edge k+161; `pass` = 1, `fail_count` = 0, `fail_addr` = 0.
- **Bit 3 of addr 5 stuck-at-0** -> fails at M2 r1 and M4 r1; `fail_count` = 2, `fail_addr` = 5, `pass` = 0.
- **Bit 0 stuck-at-1 at all addresses** -> every r0 fails (M1, M3, M5); `fail_count` = 48, `fail_addr` = 0, `pass` = 0.
- **Pulse `start` again at access 40 while busy** -> ignored; sequence and `done` timing identical to the fault-free run.
- **Assert `rst_n` low at access 70, release, then start** -> `ram_we` = 0 and `busy` = 0 during reset, no `done` pulse; the fresh run passes with full 161-cycle timing.
- **Faulty run followed by a run on a fault-free RAM** -> second accepted `start` clears the counters; final `pass` = 1, `fail_count` = 0.
